lcd_write_arbiter: RTL

LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

---
 rtl/lcd_write_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/lcd_write_arbiter.sv
// Two-client character-write arbiter in front of an LCD controller.
// Round-robin between clients, optional string lock, per-write timeout.
module lcd_write_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clkFSM,
  input  logic       resetFSM_n,
  input  logic       initDone,
  input  logic       writeDone,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       lock0,
  input  logic       lock1,
  output logic [7:0] data,
  output logic       writeStart,
  output logic       ack0,
  output logic       ack1,
  output logic       err0,
  output logic       err1,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_ARB,
    S_START,
    S_WAIT,
    S_ACK
  } state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_last;
  logic        r_lock;
  logic [19:0] r_cnt;
  logic [7:0]  r_data;
  logic        r_writeStart;
  logic [1:0]  r_ack;
  logic [1:0]  r_err;
  logic [1:0]  r_grant;
  logic        r_busy;

  logic [1:0]  w_req;
  logic [1:0]  w_lockn;
  logic        w_locked;
  logic        w_gnt_vld;
  logic        w_gnt_id;
  logic [7:0]  w_gnt_data;

  assign w_req      = {req1, req0};
  assign w_lockn    = {lock1, lock0};
  // The lock only holds while its owner (the last-served client) keeps lockN high.
  assign w_locked   = r_lock & w_lockn[r_last];
  assign w_gnt_data = w_gnt_id ? data1 : data0;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (w_locked) begin
      w_gnt_vld = w_req[r_last];
      w_gnt_id  = r_last;
    end else if (req0 && req1) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = ~r_last;
    end else if (req0 || req1) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = req1;
    end
  end

  always_ff @(posedge clkFSM or negedge resetFSM_n) begin
    if (!resetFSM_n) begin
      r_state      <= S_WAIT_INIT;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_lock       <= 1'b0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_writeStart <= 1'b0;
      r_ack        <= '0;
      r_err        <= '0;
      r_grant      <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_writeStart <= 1'b0;
      r_ack        <= '0;
      r_err        <= '0;
      case (r_state)
        S_WAIT_INIT: begin
          if (initDone) r_state <= S_ARB;
        end
        S_ARB: begin
          if (!w_locked) r_lock <= 1'b0;
          if (w_gnt_vld) begin
            r_owner      <= w_gnt_id;
            r_data       <= w_gnt_data;
            r_writeStart <= 1'b1;
            r_grant      <= w_gnt_id ? 2'b10 : 2'b01;
            r_busy       <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (writeDone || r_cnt == TO_LAST) begin
            r_ack[r_owner] <= 1'b1;
            r_err[r_owner] <= ~writeDone;
            r_data         <= '0;
            r_state        <= S_ACK;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_ACK: begin
          r_last  <= r_owner;
          // A timed-out write never keeps the lock.
          r_lock  <= w_lockn[r_owner] & ~(|r_err);
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_ARB;
        end
        default: r_state <= S_WAIT_INIT;
      endcase
    end
  end

  assign data       = r_data;
  assign writeStart = r_writeStart;
  assign ack0       = r_ack[0];
  assign ack1       = r_ack[1];
  assign err0       = r_err[0];
  assign err1       = r_err[1];
  assign grant      = r_grant;
  assign busy       = r_busy;

endmodule
